wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
// - Parametrised N-master to 1-slave Wishbone (classic, non-pipelined) arbiter; successor to the fixed 2-master shared-bus intercon.
// - Fair round-robin grant, bus held for the whole cyc; per-transfer watchdog aborts a hung slave with err.
// - Sits between CPU/DMA masters and a slave port or address decoder.
// PARAMETERS
// - NUM_MASTERS  4    number of master ports, >=1; GW = max(1,$clog2(NUM_MASTERS))
// - ADR_W        30   word address width
// - DAT_W        32   data width, multiple of 8; SEL_W = DAT_W/8
// - TIMEOUT      256  stb-without-ack cycles before abort; 0 = watchdog disabled
// PORTS
// - sys_clk    in   1              clock, all logic on rising edge
// - sys_rst_n  in   1              async active-low reset
// - m_adr_i    in   NUM_MASTERS*ADR_W  master addresses, master k at [k*ADR_W +: ADR_W]
// - m_dat_i    in   NUM_MASTERS*DAT_W  master write data
// - m_sel_i    in   NUM_MASTERS*SEL_W  master byte selects
// - m_we_i     in   NUM_MASTERS    master write enables
// - m_cyc_i    in   NUM_MASTERS    master cycle requests
// - m_stb_i    in   NUM_MASTERS    master strobes
// - m_dat_o    out  DAT_W          read data, broadcast to all masters (= s_dat_i)
// - m_ack_o    out  NUM_MASTERS    ack, granted master only
// - m_err_o    out  NUM_MASTERS    err (slave err or watchdog), granted master only
// - s_adr_o/s_dat_o/s_sel_o/s_we_o  out  ADR_W/DAT_W/SEL_W/1  muxed from granted master
// - s_cyc_o, s_stb_o  out  1       slave cycle/strobe
// - s_dat_i    in   DAT_W          slave read data
// - s_ack_i, s_err_i  in  1        slave ack / error
// - grant_o    out  NUM_MASTERS    one-hot current grant (0 when none), debug
// BEHAVIOUR
// - State reg: IDLE, BUSY, ABORT. Regs: gnt (GW), last (GW), wdog (clog2(TIMEOUT+1), min 1).
// - Reset: state=IDLE, gnt=0, last=NUM_MASTERS-1 (master 0 wins first), wdog=0; all outputs 0.
// - IDLE: if any m_cyc_i, gnt <= first requester after last (mod N, wraps), -> BUSY. Grant latency 1 cycle.
// - BUSY: s_cyc_o=m_cyc_i[gnt], s_stb_o=m_stb_i[gnt]; adr/dat/sel/we muxed combinationally.
//   m_ack_o[gnt]=s_ack_i, m_err_o[gnt]=s_err_i; other bits 0. grant_o=1<<gnt.
// - Release: m_cyc_i[gnt]==0 in BUSY -> IDLE, last<=gnt. One idle turnaround cycle between owners.
// - Other masters' cyc ignored while BUSY; no preemption.
// - Watchdog: in BUSY, wdog++ while s_stb_o & ~s_ack_i & ~s_err_i; cleared on ack/err, on stb low, leaving BUSY.
//   wdog==TIMEOUT-1 with no ack that cycle -> ABORT next edge.
// - ABORT (1 cycle): s_cyc_o=s_stb_o=0, m_err_o[gnt]=1, grant_o held; -> IDLE, last<=gnt (rotates away).
// - Ack and timeout same cycle: ack wins, no abort. TIMEOUT=0: wdog never triggers.
// - NUM_MASTERS=1: gnt constant 0, still one-cycle IDLE turnaround.
// - Reset mid-transfer: outputs drop to 0 asynchronously; state returns to IDLE.
// - No combinational path from m_cyc_i to grant; only outputs are combinational from state/gnt.
// TESTING
// - Reset: hold sys_rst_n=0 with all m_cyc_i=1 -> s_cyc_o=0, grant_o=0; release -> grant_o=4'b0001 one cycle later.
// - RR fairness: N=4, all masters loop 1-beat reads -> grants 0,1,2,3,0 with one idle cycle between each.
// - Bus hold: m1 holds cyc for 3 acked writes adr 0x10,0x11,0x12 while m0 requests -> m0 waits; m0 granted after m1 drops cyc.
// - Watchdog: TIMEOUT=8, slave never acks m2 read -> s_stb_o high 8 cycles, then m_err_o[2]=1 for 1 cycle, s_cyc_o=0.
// - Ack at limit: slave acks on the 8th stb cycle -> m_ack_o=1, m_err_o stays 0, no ABORT.
// - Data path: m3 writes 0xDEADBEEF sel 4'b0110 adr 0x3FF -> s_dat_o/s_sel_o/s_adr_o match; slave err -> m_err_o[3]=1.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave classic Wishbone arbiter: round-robin grant held for a whole cyc, watchdog abort on hung slaves.
// Latency: grant one cycle after a request in IDLE, one idle turnaround cycle between owners; data path is combinational.
// Backpressure: the slave's ack/err is routed back to the owner; other masters stall on their own cyc until they are granted.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_W       = 30,
    parameter int DAT_W       = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                                sys_clk,
    input  logic                                sys_rst_n,
    input  logic [NUM_MASTERS*ADR_W-1:0]        m_adr_i,
    input  logic [NUM_MASTERS*DAT_W-1:0]        m_dat_i,
    input  logic [NUM_MASTERS*(DAT_W/8)-1:0]    m_sel_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS-1:0]              m_cyc_i,
    input  logic [NUM_MASTERS-1:0]              m_stb_i,
    output logic [DAT_W-1:0]                    m_dat_o,
    output logic [NUM_MASTERS-1:0]              m_ack_o,
    output logic [NUM_MASTERS-1:0]              m_err_o,
    output logic [ADR_W-1:0]                    s_adr_o,
    output logic [DAT_W-1:0]                    s_dat_o,
    output logic [DAT_W/8-1:0]                  s_sel_o,
    output logic                                s_we_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    input  logic [DAT_W-1:0]                    s_dat_i,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    output logic [NUM_MASTERS-1:0]              grant_o
);

    localparam int SEL_W = DAT_W / 8;
    localparam int GW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WW    = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_MASTERS - 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        gnt, gnt_nxt;
    logic [GW-1:0]        last, last_nxt;
    logic [WW-1:0]        wdog, wdog_nxt;

    logic [GW-1:0]        rr_pick;
    logic                 rr_any;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic                 cur_cyc;
    logic                 cur_stb;
    logic [ADR_W-1:0]     mux_adr;
    logic [DAT_W-1:0]     mux_dat;
    logic [SEL_W-1:0]     mux_sel;
    logic                 mux_we;

    // Wrapped candidates (at or below last) go first so any requester above last overrides them.
    always_comb begin
        rr_any  = |m_cyc_i;
        rr_pick = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (m_cyc_i[k] && (k <= int'(last))) begin
                rr_pick = GW'(k);
            end
        end
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (m_cyc_i[k] && (k > int'(last))) begin
                rr_pick = GW'(k);
            end
        end
    end

    always_comb begin
        gnt_oh  = '0;
        mux_adr = '0;
        mux_dat = '0;
        mux_sel = '0;
        mux_we  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            gnt_oh[k] = (int'(gnt) == k);
            if (int'(gnt) == k) begin
                mux_adr = m_adr_i[k*ADR_W +: ADR_W];
                mux_dat = m_dat_i[k*DAT_W +: DAT_W];
                mux_sel = m_sel_i[k*SEL_W +: SEL_W];
                mux_we  = m_we_i[k];
            end
        end
    end

    assign cur_cyc = |(m_cyc_i & gnt_oh);
    assign cur_stb = |(m_stb_i & gnt_oh);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= LAST_RST;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        wdog_nxt  = '0;
        case (state)
            IDLE: begin
                if (rr_any) begin
                    gnt_nxt   = rr_pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!cur_cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = gnt;
                end else if (cur_stb && !s_ack_i && !s_err_i) begin
                    // A stalled strobe that reaches the limit is cut off; an ack on that same cycle never gets here.
                    if ((TIMEOUT != 0) && (wdog == WD_LIMIT)) begin
                        state_nxt = ABORT;
                    end else begin
                        wdog_nxt = wdog + 1'b1;
                    end
                end
            end
            ABORT: begin
                state_nxt = IDLE;
                last_nxt  = gnt;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m_dat_o = s_dat_i;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        grant_o = '0;
        case (state)
            BUSY: begin
                s_adr_o = mux_adr;
                s_dat_o = mux_dat;
                s_sel_o = mux_sel;
                s_we_o  = mux_we;
                s_cyc_o = cur_cyc;
                s_stb_o = cur_stb;
                m_ack_o = gnt_oh & {NUM_MASTERS{s_ack_i}};
                m_err_o = gnt_oh & {NUM_MASTERS{s_err_i}};
                grant_o = gnt_oh;
            end
            ABORT: begin
                m_err_o = gnt_oh;
                grant_o = gnt_oh;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized bench for wb_rr_arbiter against a round-robin/watchdog reference model.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic [N*AW-1:0]   m_adr_i = '0;
    logic [N*DW-1:0]   m_dat_i = '0;
    logic [N*SW-1:0]   m_sel_i = '0;
    logic [N-1:0]      m_we_i  = '0;
    logic [N-1:0]      m_cyc_i = '0;
    logic [N-1:0]      m_stb_i = '0;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o;
    logic [N-1:0]      m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic [DW-1:0]     s_dat_i = '0;
    logic              s_ack_i = 1'b0;
    logic              s_err_i = 1'b0;
    logic [N-1:0]      grant_o;

    int checks = 0;
    int errors = 0;
    int model_last;

    logic [AW-1:0] exp_adr [N];
    logic [DW-1:0] exp_dat [N];
    logic [SW-1:0] exp_sel [N];
    logic          exp_we  [N];

    wb_rr_arbiter #(
        .NUM_MASTERS (N),
        .ADR_W       (AW),
        .DAT_W       (DW),
        .TIMEOUT     (TO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_we_i    (m_we_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .grant_o   (grant_o)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: the next owner is the first requester strictly after the previous owner, wrapping.
    function automatic int rr_ref(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            if (req[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    task automatic drive_master(input int k, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                input logic [SW-1:0] sel, input logic we);
        m_adr_i[k*AW +: AW] = adr;
        m_dat_i[k*DW +: DW] = dat;
        m_sel_i[k*SW +: SW] = sel;
        m_we_i[k]  = we;
        m_cyc_i[k] = 1'b1;
        m_stb_i[k] = 1'b1;
        exp_adr[k] = adr;
        exp_dat[k] = dat;
        exp_sel[k] = sel;
        exp_we[k]  = we;
    endtask

    task automatic wait_grant(output int idle, output logic [N-1:0] g);
        idle = 0;
        g    = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            if (grant_o !== '0) begin
                g = grant_o;
                return;
            end
            idle++;
        end
        checks++;
        errors++;
        $display("FAIL grant_wait_timeout: grant_o=%b, required a nonzero grant within 20 cycles", grant_o);
    endtask

    task automatic test_reset();
        logic [N-1:0] g_exp;
        sys_rst_n = 1'b0;
        m_cyc_i = '1;
        m_stb_i = '1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_slave_idle: s_cyc_o=%b s_stb_o=%b, required 0 0", s_cyc_o, s_stb_o);
        end
        checks++;
        if (grant_o !== '0 || m_err_o !== '0 || m_ack_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant_o=%b m_ack_o=%b m_err_o=%b, required all 0", grant_o, m_ack_o, m_err_o);
        end
        sys_rst_n  = 1'b1;
        model_last = N - 1;
        g_exp = onehot(rr_ref(m_cyc_i, model_last));
        #1;
        checks++;
        if (grant_o !== '0) begin
            errors++;
            $display("FAIL reset_no_comb_grant: grant_o=%b, required 0 before the first edge", grant_o);
        end
        @(negedge sys_clk);
        checks++;
        if (grant_o !== g_exp || s_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: grant_o=%b s_cyc_o=%b, required %b 1", grant_o, s_cyc_o, g_exp);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== '0) begin
            errors++;
            $display("FAIL reset_async_mid: s_cyc_o=%b grant_o=%b, required 0 0", s_cyc_o, grant_o);
        end
        @(negedge sys_clk);
        m_cyc_i = '0;
        m_stb_i = '0;
        sys_rst_n = 1'b1;
        model_last = N - 1;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_rr_fairness();
        int idle;
        int exp;
        logic [N-1:0] g;
        logic [DW-1:0] rd;
        sys_rst_n = 1'b0;
        m_cyc_i = '1;
        m_stb_i = '1;
        m_we_i  = '0;
        @(negedge sys_clk);
        sys_rst_n  = 1'b1;
        model_last = N - 1;
        for (int r = 0; r < 5; r++) begin
            wait_grant(idle, g);
            exp = rr_ref('1, model_last);
            checks++;
            if (g !== onehot(exp) || idle !== ((r == 0) ? 0 : 1)) begin
                errors++;
                $display("FAIL rr_grant_%0d: grant_o=%b idle=%0d, required %b idle=%0d",
                         r, g, idle, onehot(exp), (r == 0) ? 0 : 1);
            end
            rd = $urandom;
            s_dat_i = rd;
            s_ack_i = 1'b1;
            #1;
            checks++;
            if (m_ack_o !== onehot(exp) || m_dat_o !== rd) begin
                errors++;
                $display("FAIL rr_read_%0d: m_ack_o=%b m_dat_o=%h, required %b %h", r, m_ack_o, m_dat_o, onehot(exp), rd);
            end
            @(posedge sys_clk);
            #1;
            s_ack_i = 1'b0;
            m_cyc_i[exp] = 1'b0;
            m_stb_i[exp] = 1'b0;
            @(posedge sys_clk);
            #1;
            model_last = exp;
            if (r < 4) begin
                m_cyc_i[exp] = 1'b1;
                m_stb_i[exp] = 1'b1;
            end else begin
                m_cyc_i = '0;
                m_stb_i = '0;
            end
        end
    endtask

    task automatic test_bus_hold();
        int idle;
        int exp;
        logic [N-1:0] g;
        drive_master(1, 30'h0, 32'h0, 4'hF, 1'b1);
        wait_grant(idle, g);
        exp = rr_ref(4'b0010, model_last);
        checks++;
        if (g !== onehot(exp)) begin
            errors++;
            $display("FAIL hold_m1_grant: grant_o=%b, required %b", g, onehot(exp));
        end
        drive_master(0, 30'h2AA, 32'h5555_0000, 4'h3, 1'b0);
        for (int b = 0; b < 3; b++) begin
            drive_master(1, AW'(32'h10 + b), $urandom, 4'hF, 1'b1);
            #1;
            checks++;
            if (s_adr_o !== exp_adr[1] || s_dat_o !== exp_dat[1] || s_we_o !== 1'b1 || grant_o !== onehot(exp)) begin
                errors++;
                $display("FAIL hold_beat_%0d: adr=%h dat=%h we=%b grant=%b, required %h %h 1 %b",
                         b, s_adr_o, s_dat_o, s_we_o, grant_o, exp_adr[1], exp_dat[1], onehot(exp));
            end
            s_ack_i = 1'b1;
            #1;
            checks++;
            if (m_ack_o !== onehot(exp)) begin
                errors++;
                $display("FAIL hold_ack_%0d: m_ack_o=%b, required %b", b, m_ack_o, onehot(exp));
            end
            @(posedge sys_clk);
            #1;
            s_ack_i = 1'b0;
            m_stb_i[1] = 1'b0;
            @(posedge sys_clk);
            #1;
        end
        m_cyc_i[1] = 1'b0;
        @(posedge sys_clk);
        #1;
        model_last = exp;
        wait_grant(idle, g);
        exp = rr_ref(4'b0001, model_last);
        checks++;
        if (g !== onehot(exp) || idle !== 1) begin
            errors++;
            $display("FAIL hold_m0_after: grant_o=%b idle=%0d, required %b idle=1", g, idle, onehot(exp));
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        @(posedge sys_clk);
        #1;
        model_last = exp;
    endtask

    task automatic test_watchdog();
        int idle;
        int cnt;
        int exp;
        logic [N-1:0] g;
        drive_master(2, 30'h123, 32'h0, 4'hF, 1'b0);
        wait_grant(idle, g);
        exp = rr_ref(4'b0100, model_last);
        checks++;
        if (g !== onehot(exp)) begin
            errors++;
            $display("FAIL wdog_grant: grant_o=%b, required %b", g, onehot(exp));
        end
        cnt = 0;
        while (s_stb_o === 1'b1 && cnt < 30) begin
            cnt++;
            @(negedge sys_clk);
        end
        checks++;
        if (cnt !== TO) begin
            errors++;
            $display("FAIL wdog_stb_cycles: stb high %0d cycles, required %0d", cnt, TO);
        end
        checks++;
        if (m_err_o !== onehot(exp) || s_cyc_o !== 1'b0 || grant_o !== onehot(exp)) begin
            errors++;
            $display("FAIL wdog_abort: m_err_o=%b s_cyc_o=%b grant_o=%b, required %b 0 %b",
                     m_err_o, s_cyc_o, grant_o, onehot(exp), onehot(exp));
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        @(posedge sys_clk);
        #1;
        model_last = exp;
        checks++;
        if (m_err_o !== '0 || grant_o !== '0) begin
            errors++;
            $display("FAIL wdog_one_cycle: m_err_o=%b grant_o=%b, required 0 0", m_err_o, grant_o);
        end
    endtask

    task automatic test_ack_at_limit();
        int idle;
        int k;
        int exp;
        logic [N-1:0] g;
        logic bad;
        k = $urandom_range(0, N - 1);
        drive_master(k, AW'($urandom), $urandom, 4'hF, 1'b0);
        wait_grant(idle, g);
        exp = rr_ref(onehot(k), model_last);
        repeat (TO - 1) @(negedge sys_clk);
        s_ack_i = 1'b1;
        #1;
        checks++;
        if (g !== onehot(exp) || m_ack_o !== onehot(exp) || m_err_o !== '0) begin
            errors++;
            $display("FAIL limit_ack: grant=%b m_ack_o=%b m_err_o=%b, required %b %b 0",
                     g, m_ack_o, m_err_o, onehot(exp), onehot(exp));
        end
        @(posedge sys_clk);
        #1;
        s_ack_i = 1'b0;
        m_stb_i[k] = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < TO + 4; c++) begin
            @(negedge sys_clk);
            if (m_err_o !== '0 || grant_o !== onehot(exp)) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL limit_no_abort: m_err_o=%b grant_o=%b, required 0 %b", m_err_o, grant_o, onehot(exp));
        end
        m_cyc_i = '0;
        @(posedge sys_clk);
        #1;
        model_last = exp;
    endtask

    task automatic test_data_path();
        int idle;
        int exp;
        logic [N-1:0] g;
        logic [DW-1:0] rd;
        for (int k = 0; k < 3; k++) begin
            m_adr_i[k*AW +: AW] = AW'($urandom);
            m_dat_i[k*DW +: DW] = $urandom;
            m_sel_i[k*SW +: SW] = 4'hF;
        end
        drive_master(3, 30'h3FF, 32'hDEADBEEF, 4'b0110, 1'b1);
        wait_grant(idle, g);
        exp = rr_ref(4'b1000, model_last);
        checks++;
        if (g !== onehot(exp) || s_dat_o !== 32'hDEADBEEF || s_sel_o !== 4'b0110 || s_adr_o !== 30'h3FF || s_we_o !== 1'b1) begin
            errors++;
            $display("FAIL data_mux: grant=%b dat=%h sel=%b adr=%h we=%b, required %b deadbeef 0110 3ff 1",
                     g, s_dat_o, s_sel_o, s_adr_o, s_we_o, onehot(exp));
        end
        rd = $urandom;
        s_dat_i = rd;
        s_err_i = 1'b1;
        #1;
        checks++;
        if (m_err_o !== onehot(exp) || m_ack_o !== '0 || m_dat_o !== rd) begin
            errors++;
            $display("FAIL data_slave_err: m_err_o=%b m_ack_o=%b m_dat_o=%h, required %b 0 %h",
                     m_err_o, m_ack_o, m_dat_o, onehot(exp), rd);
        end
        @(posedge sys_clk);
        #1;
        s_err_i = 1'b0;
        m_cyc_i = '0;
        m_stb_i = '0;
        @(posedge sys_clk);
        #1;
        model_last = exp;
    endtask

    task automatic test_random();
        int idle;
        int exp;
        int d;
        logic [N-1:0] g;
        logic [N-1:0] mask;
        for (int it = 0; it < 40; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) begin
                if (mask[k]) drive_master(k, AW'($urandom), $urandom, SW'($urandom), 1'($urandom));
            end
            wait_grant(idle, g);
            exp = rr_ref(mask, model_last);
            checks++;
            if (g !== onehot(exp) || idle !== 1) begin
                errors++;
                $display("FAIL rand_grant_%0d: grant_o=%b idle=%0d, required %b idle=1", it, g, idle, onehot(exp));
            end else begin
                checks++;
                if (s_adr_o !== exp_adr[exp] || s_dat_o !== exp_dat[exp] || s_sel_o !== exp_sel[exp] || s_we_o !== exp_we[exp]) begin
                    errors++;
                    $display("FAIL rand_mux_%0d: adr=%h dat=%h sel=%b we=%b, required %h %h %b %b", it,
                             s_adr_o, s_dat_o, s_sel_o, s_we_o, exp_adr[exp], exp_dat[exp], exp_sel[exp], exp_we[exp]);
                end
            end
            d = $urandom_range(0, TO + 2);
            if (d < TO) begin
                repeat (d) @(negedge sys_clk);
                s_ack_i = 1'b1;
                #1;
                checks++;
                if (m_ack_o !== onehot(exp) || m_err_o !== '0) begin
                    errors++;
                    $display("FAIL rand_ack_%0d: delay=%0d m_ack_o=%b m_err_o=%b, required %b 0",
                             it, d, m_ack_o, m_err_o, onehot(exp));
                end
                @(posedge sys_clk);
                #1;
                s_ack_i = 1'b0;
                m_cyc_i = '0;
                m_stb_i = '0;
                @(posedge sys_clk);
                #1;
            end else begin
                repeat (TO) @(negedge sys_clk);
                checks++;
                if (m_err_o !== onehot(exp) || s_cyc_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_abort_%0d: m_err_o=%b s_cyc_o=%b, required %b 0", it, m_err_o, s_cyc_o, onehot(exp));
                end
                m_cyc_i = '0;
                m_stb_i = '0;
                @(posedge sys_clk);
                #1;
            end
            model_last = exp;
        end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_bus_hold();
        test_watchdog();
        test_ack_at_limit();
        test_data_path();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
